// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search controller and its helpers.
package rc4_pkg;

   localparam int         S_SIZE     = 256;
   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_A     = 8'h61;
   localparam logic [7:0] CHAR_Z     = 8'h7A;

   typedef enum logic [4:0] {
      IDLE,
      INIT,
      KSA_RD_I, KSA_WT_I, KSA_RD_J, KSA_WT_J, KSA_WR_I, KSA_WR_J,
      PR_RD_I,  PR_WT_I,  PR_RD_J,  PR_WT_J,  PR_WR_I,  PR_WR_J,
      PR_RD_F,  PR_WT_F,  PR_WR_D,
      CHECK,
      DONE
   } state_t;

endpackage

// File: rtl/rc4_key_search_if.sv
// Control and memory bus between the top-level controller, the key-search block and
// its three external single-port memories (S RAM, ciphertext ROM, plaintext RAM).
interface rc4_key_search_if #(
   parameter int KEY_BYTES = 3,
   parameter int ADDR_W    = 8
);
   logic                   start;
   logic                   abort;
   logic [8*KEY_BYTES-1:0] key_start;
   logic [8*KEY_BYTES-1:0] key_end;
   logic                   busy;
   logic                   done;
   logic                   found;
   logic [8*KEY_BYTES-1:0] key_out;

   logic [ADDR_W-1:0]      s_address;
   logic [7:0]             s_data;
   logic                   s_wren;
   logic [7:0]             s_q;
   logic [ADDR_W-1:0]      rom_address;
   logic [7:0]             rom_q;
   logic [ADDR_W-1:0]      dec_address;
   logic [7:0]             dec_data;
   logic                   dec_wren;

   modport master (
      output start, abort, key_start, key_end, s_q, rom_q,
      input  busy, done, found, key_out,
      input  s_address, s_data, s_wren, rom_address, dec_address, dec_data, dec_wren
   );

   modport slave (
      input  start, abort, key_start, key_end, s_q, rom_q,
      output busy, done, found, key_out,
      output s_address, s_data, s_wren, rom_address, dec_address, dec_data, dec_wren
   );
endinterface

// File: rtl/rc4_char_check.sv
// Combinational plaintext filter: a byte is acceptable if it is a space or 'a'..'z'.
module rc4_char_check
   import rc4_pkg::*;
(
   input  logic [7:0] char_in,
   output logic       char_ok
);

   assign char_ok = (char_in == CHAR_SPACE) ||
                    ((char_in >= CHAR_A) && (char_in <= CHAR_Z));

endmodule

// File: rtl/rc4_key_search.sv
// RC4 brute-force key search: S-init, key schedule and PRGA decrypt per candidate key.
// Build option RC4_EARLY_ABORT_EN rejects a candidate at its first invalid plaintext byte.
//
// state    | meaning
// IDLE     | waiting for start; address outputs held at 0
// INIT     | S[i] = i, one write per cycle
// KSA_*    | key schedule: read S[i], wait, read S[j], wait, write S[i], write S[j]
// PR_*     | PRGA: read S[i], wait, read S[j], wait, swap (2 writes), read S[f]+rom[k], wait, write dec[k]
// CHECK    | accept candidate, stop at end of range, or advance to next key
// DONE     | one-cycle done pulse, results held
module rc4_key_search
   import rc4_pkg::*;
#(
   parameter int KEY_BYTES      = 3,
   parameter int MESSAGE_LENGTH = 32,
   parameter int ADDR_W         = 8
)
(
   input  logic             clock,
   input  logic             reset,
   rc4_key_search_if.slave  bus
);

   localparam int                KW       = 8*KEY_BYTES;
   localparam int                KIDX_W   = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [7:0]        LAST_I   = 8'(S_SIZE-1);
   localparam logic [7:0]        LAST_K   = 8'(MESSAGE_LENGTH-1);
   localparam logic [KIDX_W-1:0] LAST_KIX = KIDX_W'(KEY_BYTES-1);

   state_t            state_q, state_d;
   logic [7:0]        i_q, i_d, j_q, j_d, k_q, k_d;
   logic [7:0]        si_q, si_d, sj_q, sj_d;
   logic [KIDX_W-1:0] kidx_q, kidx_d;
   logic [KW-1:0]     cand_q, cand_d, end_q, end_d, key_out_q, key_out_d;
   logic              found_q, found_d, ok_q, ok_d;

   logic [7:0]        key_byte, f_idx, dec_byte;
   logic              char_ok, last_byte, busy;
   logic [ADDR_W-1:0] s_addr, rom_addr, dec_addr;
   logic [7:0]        s_wdata, dec_wdata;
   logic              s_we, dec_we;

   rc4_char_check u_char_check (
      .char_in (dec_byte),
      .char_ok (char_ok)
   );

   // key byte 0 is the most significant byte of the candidate
   always_comb begin
      key_byte = 8'h00;
      for (int b = 0; b < KEY_BYTES; b++) begin
         if (kidx_q == KIDX_W'(b)) key_byte = cand_q[8*(KEY_BYTES-b)-1 -: 8];
      end
   end

   assign f_idx    = si_q + sj_q;
   assign dec_byte = bus.s_q ^ bus.rom_q;
   assign busy     = (state_q != IDLE) && (state_q != DONE);

`ifdef RC4_EARLY_ABORT_EN
   assign last_byte = (k_q == LAST_K) || !char_ok;
`else
   assign last_byte = (k_q == LAST_K);
`endif

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      k_d       = k_q;
      si_d      = si_q;
      sj_d      = sj_q;
      kidx_d    = kidx_q;
      cand_d    = cand_q;
      end_d     = end_q;
      key_out_d = key_out_q;
      found_d   = found_q;
      ok_d      = ok_q;
      s_addr    = '0;
      s_wdata   = 8'h00;
      s_we      = 1'b0;
      rom_addr  = '0;
      dec_addr  = '0;
      dec_wdata = 8'h00;
      dec_we    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               cand_d  = bus.key_start;
               end_d   = bus.key_end;
               found_d = 1'b0;
               if (bus.key_start > bus.key_end) begin
                  key_out_d = bus.key_start;
                  state_d   = DONE;
               end else begin
                  key_out_d = '0;
                  i_d       = 8'h00;
                  state_d   = INIT;
               end
            end
         end
         INIT: begin
            s_addr  = ADDR_W'(i_q);
            s_wdata = i_q;
            s_we    = 1'b1;
            i_d     = i_q + 8'd1;
            if (i_q == LAST_I) begin
               j_d     = 8'h00;
               kidx_d  = '0;
               state_d = KSA_RD_I;
            end
         end
         KSA_RD_I, KSA_WT_I: begin
            s_addr  = ADDR_W'(i_q);
            state_d = (state_q == KSA_RD_I) ? KSA_WT_I : KSA_RD_J;
         end
         KSA_RD_J: begin
            si_d    = bus.s_q;
            j_d     = j_q + bus.s_q + key_byte;
            s_addr  = ADDR_W'(j_d);
            kidx_d  = (kidx_q == LAST_KIX) ? '0 : kidx_q + KIDX_W'(1);
            state_d = KSA_WT_J;
         end
         KSA_WT_J, PR_WT_J: begin
            s_addr  = ADDR_W'(j_q);
            state_d = (state_q == KSA_WT_J) ? KSA_WR_I : PR_WR_I;
         end
         KSA_WR_I, PR_WR_I: begin
            s_addr  = ADDR_W'(i_q);
            s_wdata = bus.s_q;
            s_we    = 1'b1;
            sj_d    = bus.s_q;
            state_d = (state_q == KSA_WR_I) ? KSA_WR_J : PR_WR_J;
         end
         KSA_WR_J: begin
            s_addr  = ADDR_W'(j_q);
            s_wdata = si_q;
            s_we    = 1'b1;
            i_d     = i_q + 8'd1;
            if (i_q == LAST_I) begin
               j_d     = 8'h00;
               k_d     = 8'h00;
               ok_d    = 1'b1;
               state_d = PR_RD_I;
            end else begin
               state_d = KSA_RD_I;
            end
         end
         PR_RD_I: begin
            i_d     = i_q + 8'd1;
            s_addr  = ADDR_W'(i_d);
            state_d = PR_WT_I;
         end
         PR_WT_I: begin
            s_addr  = ADDR_W'(i_q);
            state_d = PR_RD_J;
         end
         PR_RD_J: begin
            si_d    = bus.s_q;
            j_d     = j_q + bus.s_q;
            s_addr  = ADDR_W'(j_d);
            state_d = PR_WT_J;
         end
         PR_WR_J: begin
            s_addr  = ADDR_W'(j_q);
            s_wdata = si_q;
            s_we    = 1'b1;
            state_d = PR_RD_F;
         end
         PR_RD_F, PR_WT_F: begin
            s_addr   = ADDR_W'(f_idx);
            rom_addr = ADDR_W'(k_q);
            state_d  = (state_q == PR_RD_F) ? PR_WT_F : PR_WR_D;
         end
         PR_WR_D: begin
            dec_addr  = ADDR_W'(k_q);
            dec_wdata = dec_byte;
            dec_we    = 1'b1;
            ok_d      = ok_q & char_ok;
            k_d       = k_q + 8'd1;
            state_d   = last_byte ? CHECK : PR_RD_I;
         end
         CHECK: begin
            if (ok_q) begin
               found_d   = 1'b1;
               key_out_d = cand_q;
               state_d   = DONE;
            end else if (cand_q == end_q) begin
               key_out_d = cand_q;
               state_d   = DONE;
            end else begin
               cand_d  = cand_q + KW'(1);
               i_d     = 8'h00;
               state_d = INIT;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // abort overrides every busy-state decision; the write issued this cycle still lands
      if (busy && bus.abort) begin
         found_d   = 1'b0;
         key_out_d = cand_q;
         state_d   = DONE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         i_q       <= 8'h00;
         j_q       <= 8'h00;
         k_q       <= 8'h00;
         si_q      <= 8'h00;
         sj_q      <= 8'h00;
         kidx_q    <= '0;
         cand_q    <= '0;
         end_q     <= '0;
         key_out_q <= '0;
         found_q   <= 1'b0;
         ok_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         j_q       <= j_d;
         k_q       <= k_d;
         si_q      <= si_d;
         sj_q      <= sj_d;
         kidx_q    <= kidx_d;
         cand_q    <= cand_d;
         end_q     <= end_d;
         key_out_q <= key_out_d;
         found_q   <= found_d;
         ok_q      <= ok_d;
      end
   end

   assign bus.busy        = busy;
   assign bus.done        = (state_q == DONE);
   assign bus.found       = found_q;
   assign bus.key_out     = key_out_q;
   assign bus.s_address   = s_addr;
   assign bus.s_data      = s_wdata;
   assign bus.s_wren      = s_we;
   assign bus.rom_address = rom_addr;
   assign bus.dec_address = dec_addr;
   assign bus.dec_data    = dec_wdata;
   assign bus.dec_wren    = dec_we;

endmodule

// File: tb/tb_rc4_key_search.sv
// Directed bench for rc4_key_search with behavioural S RAM, ciphertext ROM and plaintext RAM.
module tb_rc4_key_search;

   localparam int CAND_CYCLES = 256 + 256*6 + 32*9 + 1;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   done_cnt = 0;

   logic [7:0] s_mem   [256];
   logic [7:0] rom     [256];
   logic [7:0] dec_mem [256];
   logic [7:0] plain   [32];

   rc4_key_search_if #(.KEY_BYTES(3), .ADDR_W(8)) bus ();

   rc4_key_search #(.KEY_BYTES(3), .MESSAGE_LENGTH(32), .ADDR_W(8)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single-port memories with registered read: q valid the cycle after the address
   always @(posedge clk) begin
      if (bus.s_wren) s_mem[bus.s_address] <= bus.s_data;
      bus.s_q   <= s_mem[bus.s_address];
      bus.rom_q <= rom[bus.rom_address];
      if (bus.dec_wren) dec_mem[bus.dec_address] <= bus.dec_data;
   end

   always @(negedge clk) if (bus.done) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference RC4: encrypt the padded plaintext into the ROM under a 3-byte key
   task automatic load_rom(input logic [23:0] key);
      logic [7:0] s [256];
      logic [7:0] kb [3];
      logic [7:0] i, j, t, tmp;
      kb[0] = key[23:16];
      kb[1] = key[15:8];
      kb[2] = key[7:0];
      for (int n = 0; n < 256; n++) begin
         s[n]   = 8'(n);
         rom[n] = 8'h00;
      end
      j = 8'h00;
      for (int n = 0; n < 256; n++) begin
         j    = j + s[n] + kb[n % 3];
         tmp  = s[n];
         s[n] = s[j];
         s[j] = tmp;
      end
      i = 8'h00;
      j = 8'h00;
      for (int k = 0; k < 32; k++) begin
         i      = i + 8'd1;
         j      = j + s[i];
         tmp    = s[i];
         s[i]   = s[j];
         s[j]   = tmp;
         t      = s[i] + s[j];
         rom[k] = s[t] ^ plain[k];
      end
   endtask

   // pulse start, then follow the run until done or the cycle budget runs out
   task automatic run_search(input logic [23:0] ks, input logic [23:0] ke, input int limit,
                             input int abort_at, input int poke_at,
                             output int lat, output int bc,
                             output logic f0, output logic [23:0] k0, output logic b0);
      logic got;
      got = 1'b0;
      bc  = 0;
      @(negedge clk);
      bus.start     = 1'b1;
      bus.key_start = ks;
      bus.key_end   = ke;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      f0  = bus.found;
      k0  = bus.key_out;
      b0  = bus.busy;
      while (lat <= limit) begin
         if (bus.busy) bc++;
         if (bus.done) begin
            got = 1'b1;
            break;
         end
         bus.abort = (lat == abort_at);
         bus.start = (lat == poke_at);
         @(negedge clk);
         lat++;
      end
      bus.abort = 1'b0;
      bus.start = 1'b0;
      chk("done_within_budget", 32'(got), 32'd1);
   endtask

   initial begin
      int          lat, bc, d0, wr, bad;
      logic        f0, b0;
      logic [23:0] k0;
      string       msg;

      msg = "attack at dawn";
      for (int k = 0; k < 32; k++) plain[k] = (k < msg.len()) ? msg[k] : 8'h20;
      load_rom(24'h000018);

      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.key_start = 24'h0;
      bus.key_end   = 24'h0;

      // reset with start held high: nothing may be accepted
      rst           = 1'b1;
      bus.start     = 1'b1;
      bus.key_start = 24'h000005;
      bus.key_end   = 24'h000004;
      repeat (3) @(negedge clk);
      chk("rst_busy",     32'(bus.busy),        32'd0);
      chk("rst_done",     32'(bus.done),        32'd0);
      chk("rst_found",    32'(bus.found),       32'd0);
      chk("rst_key_out",  32'(bus.key_out),     32'd0);
      chk("rst_s_wren",   32'(bus.s_wren),      32'd0);
      chk("rst_s_addr",   32'(bus.s_address),   32'd0);
      chk("rst_rom_addr", 32'(bus.rom_address), 32'd0);
      chk("rst_dec_wren", 32'(bus.dec_wren),    32'd0);
      rst       = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      chk("rst_start_ignored_busy", 32'(bus.busy),    32'd0);
      chk("rst_start_ignored_key",  32'(bus.key_out), 32'd0);

      // success: key 0x18 inside 0x00..0x3F
      d0 = done_cnt;
      run_search(24'h000000, 24'h00003F, 60000, 0, 0, lat, bc, f0, k0, b0);
      chk("succ_busy_first", 32'(b0), 32'd1);
      chk("succ_found",   32'(bus.found),   32'd1);
      chk("succ_key_out", 32'(bus.key_out), 32'h18);
      chk("succ_busy_at_done", 32'(bus.busy), 32'd0);
      repeat (4) @(negedge clk);
      chk("succ_done_pulses", 32'(done_cnt - d0), 32'd1);
      bad = 0;
      for (int k = 0; k < 32; k++) if (dec_mem[k] !== plain[k]) bad++;
      chk("succ_dec_ram", 32'(bad), 32'd0);
`ifdef RC4_EARLY_ABORT_EN
      chk("succ_cycles_fewer", 32'(bc < 25*CAND_CYCLES), 32'd1);
`else
      chk("succ_cycles", 32'(bc), 32'(25*CAND_CYCLES));
`endif

      // exhausted range, with a stray start mid-run that must be ignored
      d0 = done_cnt;
      run_search(24'h000020, 24'h000023, 12000, 0, 100, lat, bc, f0, k0, b0);
      chk("exh_found_cleared",   32'(f0), 32'd0);
      chk("exh_key_out_cleared", 32'(k0), 32'd0);
      chk("exh_busy_first",      32'(b0), 32'd1);
      chk("exh_found",   32'(bus.found),   32'd0);
      chk("exh_key_out", 32'(bus.key_out), 32'h23);
      repeat (4) @(negedge clk);
      chk("exh_done_pulses", 32'(done_cnt - d0), 32'd1);
`ifndef RC4_EARLY_ABORT_EN
      chk("exh_cycles", 32'(bc), 32'(4*CAND_CYCLES));
`endif

      // abort in the key schedule of the second candidate
      run_search(24'h000030, 24'h00003F, 6000, CAND_CYCLES + 256 + 100, 0, lat, bc, f0, k0, b0);
      chk("abort_latency", 32'(lat - (CAND_CYCLES + 256 + 100) <= 2), 32'd1);
      chk("abort_found",   32'(bus.found),   32'd0);
      chk("abort_key_out", 32'(bus.key_out), 32'h31);
      wr = 0;
      for (int c = 0; c < 10; c++) begin
         if (bus.s_wren || bus.dec_wren) wr++;
         @(negedge clk);
      end
      chk("abort_no_writes_after", 32'(wr), 32'd0);

      // single-key range hitting the right key
      run_search(24'h000018, 24'h000018, 4000, 0, 0, lat, bc, f0, k0, b0);
      chk("one_found",   32'(bus.found),   32'd1);
      chk("one_key_out", 32'(bus.key_out), 32'h18);

      // reversed range
      run_search(24'h000005, 24'h000004, 10, 0, 0, lat, bc, f0, k0, b0);
      chk("rev_latency", 32'(lat <= 2),      32'd1);
      chk("rev_found",   32'(bus.found),     32'd0);
      chk("rev_key_out", 32'(bus.key_out),   32'h5);
      chk("rev_no_busy", 32'(bc),            32'd0);

      // reset in the middle of a search
      @(negedge clk);
      bus.start     = 1'b1;
      bus.key_start = 24'h000000;
      bus.key_end   = 24'h00003F;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (50) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy",   32'(bus.busy),    32'd0);
      chk("midrst_s_wren", 32'(bus.s_wren),  32'd0);
      chk("midrst_key",    32'(bus.key_out), 32'd0);
      @(negedge clk);
      chk("midrst_idle", 32'(bus.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
